multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multi-cycle RISC-V datapath: fetch, decode, execute, memory access and writeback over several clocks.
- Supported instructions: lw, sw, R-type, addi, beq and bne.
- Drives the PC, instruction register, memory, register file and ALU-operand mux controls.
- Replaces the single-cycle opcode decoder.
- Waits on a unified memory through a ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the stateDbg port.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcodeCtrl  in  7  instruction[6:0] from the instruction register.
- funct3Ctrl  in  3  instruction[14:12] from the instruction register.
- zeroCtrl  in  1  ALU zero flag.
- memReadyCtrl  in  1  memory has completed the current read/write this cycle.
- pcWriteCtrl  out  1  load PC.
- pcSrcCtrl  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- irWriteCtrl  out  1  load instruction register.
- iorDCtrl  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemReadCtrl  out  1  memory read request.
- MemWriteCtrl  out  1  memory write request.
- ALUSrcACtrl  out  2  00 = PC, 01 = rs1, 10 = oldPC.
- ALUSrcBCtrl  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOpCtrl  out  2  00 = add, 01 = subtract (branch compare), 10 = funct decode (R-type).
- RegWriteCtrl  out  1  register file write.
- MemToRegCtrl  out  1  writeback source: 0 = ALUOut, 1 = memory data register.
- instrDoneCtrl  out  1  one-cycle pulse in the final cycle of each instruction.
- illegalCtrl  out  1  illegal instruction detected.
- stateDbg  out  STATE_W  current state encoding.

Behaviour:
- Reset is synchronous.
  - Rising edge with reset=1: state <= FETCH (0).
  - While reset=1: every output is forced to 0, including stateDbg.
  - Reset asserted mid-instruction aborts the instruction; no write strobes are asserted in that cycle.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, TRAP=10.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemReadCtrl=1, iorD=0, SrcA=00, SrcB=01, ALUOp=00, pcSrc=0.
  - irWrite and pcWrite are 1 only when memReady=1.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - Outputs: SrcA=10, SrcB=10, ALUOp=00; the branch target is latched into ALUOut.
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; any other opcode -> illegal handling.
- MEMADR:
  - Outputs: SrcA=01, SrcB=10, ALUOp=00.
  - Goes to MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: MemReadCtrl=1, iorD=1.
  - Waits for memReady, then goes to MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, MemToReg=1, instrDone=1.
  - Goes to FETCH.
- MEMWR:
  - Outputs: MemWriteCtrl=1, iorD=1.
  - Waits for memReady; in the cycle memReady=1, instrDone=1 and the next state is FETCH.
- EXEC_R: SrcA=01, SrcB=00, ALUOp=10; goes to ALUWB.
- EXEC_I: SrcA=01, SrcB=10, ALUOp=00; goes to ALUWB.
- ALUWB: RegWrite=1, MemToReg=0, instrDone=1; goes to FETCH.
- BRANCH:
  - Outputs: SrcA=01, SrcB=00, ALUOp=01, pcSrc=1, instrDone=1.
  - pcWrite = (funct3==000 & zero) | (funct3==001 & !zero).
  - funct3 not equal to 000 or 001 is illegal; pcWrite=0.
  - Goes to FETCH.
- Latency in cycles, assuming memReady=1 on first request:
  - lw: 5
  - sw: 4
  - R-type / addi: 4
  - branch: 3
  - Every cycle of memReady=0 adds one cycle.
- A memReady pulse in a state with no memory request is ignored.
- No outputs are X in any state; an unknown state register value returns to FETCH on the next edge.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode (seen in DECODE) or illegal branch funct3 (seen in BRANCH) goes to TRAP.
  - TRAP: illegalCtrl=1 and all other outputs 0.
  - The FSM stays in TRAP until reset.
- Undefined:
  - An illegal instruction is a NOP: the FSM goes to FETCH, pulsing instrDone in the detecting cycle.
  - illegalCtrl is tied to 0, and the TRAP state is unreachable.

Test Plan:
- Reset, then release, memReady=1 and opcode=0110011 -> stateDbg sequence 0,1,6,8,0; irWrite and pcWrite=1 in cycle 0; RegWrite=1 and instrDone=1 in cycle 3; ALUOp=10 in cycle 2.
- lw (0000011) with memReady low for 2 cycles in MEMRD -> stays in state 3 for 3 cycles with MemRead=1, iorD=1; then state 4 with MemToReg=1, RegWrite=1.
- sw (0100011), memReady=1 -> states 0,1,2,5,0; MemWrite=1 only in state 5; RegWrite never 1.
- beq (funct3=000): zero=1 -> pcWrite=1, pcSrc=1 in BRANCH; zero=0 -> pcWrite=0. bne (001) -> the opposite.
- Opcode 1111111 -> with CTRL_ILLEGAL_TRAP_EN: stateDbg=10, illegalCtrl=1, held for 10 cycles, then reset returns to 0. Without it: back to FETCH after DECODE, illegalCtrl=0.
- reset asserted while in MEMWR with memReady=0 -> all outputs 0 during reset; stateDbg=0 after release; no MemWrite in the reset cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle RISC-V datapath (lw, sw, R-type, addi, beq, bne).
// Define CTRL_ILLEGAL_TRAP_EN to lock illegal instructions in TRAP; otherwise they retire as NOPs.
module multicycle_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcodeCtrl,
  input  logic [2:0]         funct3Ctrl,
  input  logic               zeroCtrl,
  input  logic               memReadyCtrl,
  output logic               pcWriteCtrl,
  output logic               pcSrcCtrl,
  output logic               irWriteCtrl,
  output logic               iorDCtrl,
  output logic               MemReadCtrl,
  output logic               MemWriteCtrl,
  output logic [1:0]         ALUSrcACtrl,
  output logic [1:0]         ALUSrcBCtrl,
  output logic [1:0]         ALUOpCtrl,
  output logic               RegWriteCtrl,
  output logic               MemToRegCtrl,
  output logic               instrDoneCtrl,
  output logic               illegalCtrl,
  output logic [STATE_W-1:0] stateDbg
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC_R = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXEC_I = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(10);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              ctrl_c;
  logic               br_legal_c;
  logic               br_taken_c;

  // Branch condition from funct3 and the ALU zero flag of rs1 - rs2.
  always_comb begin
    br_legal_c = (funct3Ctrl == F3_BEQ) || (funct3Ctrl == F3_BNE);
    br_taken_c = ((funct3Ctrl == F3_BEQ) &&  zeroCtrl) ||
                 ((funct3Ctrl == F3_BNE) && !zeroCtrl);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_a = SRCA_PC;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.ir_write  = memReadyCtrl;
        ctrl_c.pc_write  = memReadyCtrl;
        if (memReadyCtrl) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures oldPC + imm, the branch target used later in BRANCH.
        ctrl_c.alu_src_a = SRCA_OLDPC;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        case (opcodeCtrl)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        state_d          = (opcodeCtrl == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.ior_d    = 1'b1;
        if (memReadyCtrl) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.ior_d     = 1'b1;
        if (memReadyCtrl) begin
          ctrl_c.instr_done = 1'b1;
          state_d           = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_RS2;
        ctrl_c.alu_op    = ALU_FUNCT;
        state_d          = S_ALUWB;
      end
      S_EXEC_I: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b0;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_RS2;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_src    = 1'b1;
        if (br_legal_c) begin
          ctrl_c.pc_write   = br_taken_c;
          ctrl_c.instr_done = 1'b1;
          state_d           = S_FETCH;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          ctrl_c.instr_done = 1'b1;
          state_d           = S_FETCH;
`endif
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl_c.illegal = 1'b1;
        state_d        = S_TRAP;
      end
`else
      S_TRAP: begin
        state_d = S_FETCH;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset masks every output so an aborted instruction issues no strobes.
  assign pcWriteCtrl   = ~reset & ctrl_c.pc_write;
  assign pcSrcCtrl     = ~reset & ctrl_c.pc_src;
  assign irWriteCtrl   = ~reset & ctrl_c.ir_write;
  assign iorDCtrl      = ~reset & ctrl_c.ior_d;
  assign MemReadCtrl   = ~reset & ctrl_c.mem_read;
  assign MemWriteCtrl  = ~reset & ctrl_c.mem_write;
  assign ALUSrcACtrl   = reset ? 2'b00 : ctrl_c.alu_src_a;
  assign ALUSrcBCtrl   = reset ? 2'b00 : ctrl_c.alu_src_b;
  assign ALUOpCtrl     = reset ? 2'b00 : ctrl_c.alu_op;
  assign RegWriteCtrl  = ~reset & ctrl_c.reg_write;
  assign MemToRegCtrl  = ~reset & ctrl_c.mem_to_reg;
  assign instrDoneCtrl = ~reset & ctrl_c.instr_done;
  assign illegalCtrl   = ~reset & ctrl_c.illegal;
  assign stateDbg      = reset ? '0 : state_q;

endmodule
